regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 31 +++
 rtl/regfile_mp.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, register-index constants and address type for the register file
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF = $clog2(NREG_DEF);
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_0800;
    localparam int X0 = 0;
    localparam int SP = 2;
    typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; claims set, committed writes clear, claim wins
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWP = 2,
    parameter int AW = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWP-1:0]          wr_en,
    input  logic [NWP-1:0][AW-1:0]  wr_addr,
    input  logic                    claim_en,
    input  logic [AW-1:0]           claim_addr,
    output logic [NREG-1:0]         busy
);
    logic [NREG-1:0] nxt;

    always_comb begin
        nxt = busy;
        for (int p = 0; p < NWP; p++)
            if (wr_en[p] && wr_addr[p] != AW'(X0)) nxt[wr_addr[p]] = 1'b0;
        if (claim_en && claim_addr != AW'(X0)) nxt[claim_addr] = 1'b1;
        nxt[X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy <= '0;
        else      busy <= nxt;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, optional write-to-read bypass
// and an issue scoreboard; higher write port wins address collisions.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP = 2,
    parameter int NWP = 2,
    parameter int BYPASS = 1,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    parameter int AW = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRP-1:0][AW-1:0]    rs_addr_i,
    output logic [NRP-1:0][XLEN-1:0]  rs_data_o,
    output logic [NRP-1:0]            rs_busy_o,
    input  logic [NWP-1:0]            wr_en_i,
    input  logic [NWP-1:0][AW-1:0]    wr_addr_i,
    input  logic [NWP-1:0][XLEN-1:0]  wr_data_i,
    input  logic                      claim_en_i,
    input  logic [AW-1:0]             claim_addr_i,
    output logic [NREG-1:0]           busy_o,
    output logic                      conflict_o
);
    logic [XLEN-1:0] regs [NREG];
    logic coll;

    generate
        if (NWP == 2) begin : g_col
            assign coll = wr_en_i[0] & wr_en_i[1] & (wr_addr_i[0] == wr_addr_i[1]) & (wr_addr_i[0] != AW'(X0));
        end else begin : g_nocol
            assign coll = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= (i == SP) ? SP_INIT : '0;
            conflict_o <= 1'b0;
        end else begin
            for (int p = 0; p < NWP; p++)
                if (wr_en_i[p] && wr_addr_i[p] != AW'(X0)) regs[wr_addr_i[p]] <= wr_data_i[p];
            conflict_o <= coll;
        end
    end

    // Ascending port scan lets port 1 override port 0 on the bypass path too.
    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int r = 0; r < NRP; r++) begin : g_rd
            logic [XLEN-1:0] d;
            logic w;
            d = regs[rs_addr_i[r]];
            w = 1'b0;
            for (int p = 0; p < NWP; p++)
                if (wr_en_i[p] && wr_addr_i[p] == rs_addr_i[r]) begin
                    w = 1'b1;
                    if (BYPASS != 0) d = wr_data_i[p];
                end
            rs_data_o[r] = (rs_addr_i[r] == AW'(X0)) ? '0 : d;
            rs_busy_o[r] = busy_o[rs_addr_i[r]] & ~((BYPASS != 0) && w && !(claim_en_i && claim_addr_i == rs_addr_i[r]));
        end
    end

    regfile_scoreboard #(.NREG(NREG), .NWP(NWP), .AW(AW)) u_sb (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en_i),
        .wr_addr(wr_addr_i),
        .claim_en(claim_en_i),
        .claim_addr(claim_addr_i),
        .busy(busy_o)
    );
endmodule
